// File: rtl/processor_mc.sv
// processor_mc - multi-cycle RV32I core.
//
// Each instruction walks FETCH -> EXEC -> (MEM) -> WB. HALT is entered
// from EXEC on ebreak, on misaligned data accesses or jump targets, and
// (optionally) on undecodable opcodes. Instruction and data memories use
// independent req/ready handshakes, so wait-stated memories just stretch
// FETCH or MEM.
//
// Ports
//   clk, rst        single clock; synchronous active-high reset
//   imem_*          fetch request / address (== current_pc) / ready / data
//   dmem_*          data request, write enable, byte enables, word address,
//                   lane-replicated store data, ready, load data
//   dbg_reg_addr/val combinational register-file peek (x0 reads 0)
//   current_pc      PC of the instruction in flight
//   instret         retired-instruction counter (wraps)
//   halted          high while in HALT
module processor_mc #(
    parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
    parameter int          CNT_W           = 32,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [3:0]       dmem_be,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    input  logic             dmem_ready,
    input  logic [31:0]      dmem_rdata,
    input  logic [4:0]       dbg_reg_addr,
    output logic [31:0]      dbg_reg_val,
    output logic [31:0]      current_pc,
    output logic [CNT_W-1:0] instret,
    output logic             halted
);

    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_REG    = 7'b0110011;
    localparam logic [6:0]  OP_FENCE  = 7'b0001111;
    localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
    localparam logic [31:0] EBREAK    = 32'h0010_0073;

    typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, HALT} state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             imemReq_q, imemReq_d;
    logic             dmemReq_q, dmemReq_d;
    logic             dmemWe_q, dmemWe_d;
    logic [3:0]       dmemBe_q, dmemBe_d;
    logic [31:0]      dmemAddr_q, dmemAddr_d;
    logic [31:0]      dmemWdata_q, dmemWdata_d;
    logic [31:0]      loadData_q, loadData_d;
    logic [31:0]      rf_q [32];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1Addr, rs2Addr;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] immI, immS, immB, immU, immJ;
    logic [31:0] rs1Val, rs2Val, aluB, aluRes, pcPlus4, jumpTarget, nextPc;
    logic [31:0] ea, storeData, loadExt, wbData;
    logic [15:0] loadHalf;
    logic [7:0]  loadByte;
    logic [3:0]  storeBe;
    logic        isLui, isAuipc, isJal, isJalr, isBranch, isLoad, isStore;
    logic        isOpImm, isOp, isEbreak, illegal;
    logic        brCond, brTaken, takeJump, misTarget, misData, fault, rfWe;
    logic        rfRstN;

    // Instruction fields and immediates are always taken from the latched IR,
    // so they stay valid through EXEC, MEM and WB.
    assign opcode   = ir_q[6:0];
    assign rd       = ir_q[11:7];
    assign funct3   = ir_q[14:12];
    assign rs1Addr  = ir_q[19:15];
    assign rs2Addr  = ir_q[24:20];
    assign funct7b5 = ir_q[30];
    assign immI = {{20{ir_q[31]}}, ir_q[31:20]};
    assign immS = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign immB = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign immU = {ir_q[31:12], 12'b0};
    assign immJ = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    // The register file is only written in WB, so these reads are stable for
    // the whole instruction; x0 is never written and stays zero.
    assign rs1Val      = rf_q[rs1Addr];
    assign rs2Val      = rf_q[rs2Addr];
    assign dbg_reg_val = rf_q[dbg_reg_addr];

    // Opcode decode. Unsupported funct3 encodings of a known opcode count as
    // illegal and leave every class flag low, so with halting disabled they
    // fall through as a NOP.
    always_comb begin
        isLui    = 1'b0;
        isAuipc  = 1'b0;
        isJal    = 1'b0;
        isJalr   = 1'b0;
        isBranch = 1'b0;
        isLoad   = 1'b0;
        isStore  = 1'b0;
        isOpImm  = 1'b0;
        isOp     = 1'b0;
        isEbreak = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_LUI:    isLui   = 1'b1;
            OP_AUIPC:  isAuipc = 1'b1;
            OP_JAL:    isJal   = 1'b1;
            OP_JALR: begin
                illegal = (funct3 != 3'b000);
                isJalr  = !illegal;
            end
            OP_BRANCH: begin
                illegal  = (funct3[2:1] == 2'b01);
                isBranch = !illegal;
            end
            OP_LOAD: begin
                illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
                isLoad  = !illegal;
            end
            OP_STORE: begin
                illegal = funct3[2] || (funct3[1:0] == 2'b11);
                isStore = !illegal;
            end
            OP_IMM:    isOpImm = 1'b1;
            OP_REG: begin
                illegal = !((ir_q[31:25] == 7'h00) ||
                            ((ir_q[31:25] == 7'h20) && (funct3 == 3'b000 || funct3 == 3'b101)));
                isOp    = !illegal;
            end
            OP_FENCE:  ;
            OP_SYSTEM: begin
                isEbreak = (ir_q == EBREAK);
                illegal  = !isEbreak;
            end
            default:   illegal = 1'b1;
        endcase
    end

    // Integer ALU shared by register-register and register-immediate forms.
    // Only the register form can subtract; bit 30 selects arithmetic shift
    // in both forms.
    assign aluB = isOp ? rs2Val : immI;

    always_comb begin
        aluRes = '0;
        case (funct3)
            3'b000: aluRes = (isOp && funct7b5) ? rs1Val - aluB : rs1Val + aluB;
            3'b001: aluRes = rs1Val << aluB[4:0];
            3'b010: aluRes = {31'b0, ($signed(rs1Val) < $signed(aluB))};
            3'b011: aluRes = {31'b0, (rs1Val < aluB)};
            3'b100: aluRes = rs1Val ^ aluB;
            3'b101: aluRes = funct7b5 ? ($signed(rs1Val) >>> aluB[4:0]) : (rs1Val >> aluB[4:0]);
            3'b110: aluRes = rs1Val | aluB;
            3'b111: aluRes = rs1Val & aluB;
            default: aluRes = '0;
        endcase
    end

    // Branch comparator: funct3[2:1] picks eq / signed lt / unsigned lt and
    // funct3[0] inverts the sense (bne, bge, bgeu).
    always_comb begin
        case (funct3[2:1])
            2'b00:   brCond = (rs1Val == rs2Val);
            2'b10:   brCond = ($signed(rs1Val) < $signed(rs2Val));
            default: brCond = (rs1Val < rs2Val);
        endcase
    end

    assign brTaken = isBranch && (brCond ^ funct3[0]);

    // Next-PC selection; a taken transfer to a non-word-aligned target is a
    // fault, caught in EXEC before anything architectural changes.
    always_comb begin
        jumpTarget = pc_q + immB;
        if (isJal) begin
            jumpTarget = pc_q + immJ;
        end else if (isJalr) begin
            jumpTarget = (rs1Val + immI) & ~32'd1;
        end
    end

    assign pcPlus4   = pc_q + 32'd4;
    assign takeJump  = isJal || isJalr || brTaken;
    assign nextPc    = takeJump ? jumpTarget : pcPlus4;
    assign misTarget = takeJump && (jumpTarget[1:0] != 2'b00);

    // Effective address and alignment check for sized accesses.
    assign ea      = rs1Val + (isStore ? immS : immI);
    assign misData = (isLoad || isStore) &&
                     (((funct3[1:0] == 2'b01) && ea[0]) ||
                      ((funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00)));
    assign fault   = misData || misTarget || (illegal && HALT_ON_ILLEGAL);

    // Store lane steering: data is replicated across all lanes so the
    // byte enables alone select which bytes memory updates.
    always_comb begin
        storeBe   = 4'b1111;
        storeData = rs2Val;
        case (funct3[1:0])
            2'b00: begin
                storeBe   = 4'b0001 << ea[1:0];
                storeData = {4{rs2Val[7:0]}};
            end
            2'b01: begin
                storeBe   = ea[1] ? 4'b1100 : 4'b0011;
                storeData = {2{rs2Val[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane extraction and sign/zero extension from the returned word.
    assign loadByte = dmem_rdata[{ea[1:0], 3'b000} +: 8];
    assign loadHalf = ea[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        case (funct3)
            3'b000:  loadExt = {{24{loadByte[7]}}, loadByte};
            3'b001:  loadExt = {{16{loadHalf[15]}}, loadHalf};
            3'b100:  loadExt = {24'b0, loadByte};
            3'b101:  loadExt = {16'b0, loadHalf};
            default: loadExt = dmem_rdata;
        endcase
    end

    // Write-back value; all operands are still stable in WB because the
    // register file and PC only change on the WB edge itself.
    always_comb begin
        wbData = aluRes;
        if (isLui) begin
            wbData = immU;
        end else if (isAuipc) begin
            wbData = pc_q + immU;
        end else if (isJal || isJalr) begin
            wbData = pcPlus4;
        end else if (isLoad) begin
            wbData = loadData_q;
        end
    end

    assign rfWe = isLui || isAuipc || isJal || isJalr || isLoad || isOp || isOpImm;

    // Control FSM next-state logic. Every request output is registered, so
    // the next-state values of the request registers are produced here too;
    // a request register only drops in the cycle its ready is seen.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        instret_d   = instret_q;
        imemReq_d   = imemReq_q;
        dmemReq_d   = dmemReq_q;
        dmemWe_d    = dmemWe_q;
        dmemBe_d    = dmemBe_q;
        dmemAddr_d  = dmemAddr_q;
        dmemWdata_d = dmemWdata_q;
        loadData_d  = loadData_q;
        case (state_q)
            FETCH: begin
                imemReq_d = 1'b1;
                if (imemReq_q && imem_ready) begin
                    ir_d      = imem_rdata;
                    imemReq_d = 1'b0;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (fault || isEbreak) begin
                    state_d = HALT;
                end else if (isLoad || isStore) begin
                    dmemReq_d   = 1'b1;
                    dmemWe_d    = isStore;
                    dmemBe_d    = isStore ? storeBe : 4'b0000;
                    dmemAddr_d  = {ea[31:2], 2'b00};
                    dmemWdata_d = storeData;
                    state_d     = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (dmemReq_q && dmem_ready) begin
                    loadData_d = loadExt;
                    dmemReq_d  = 1'b0;
                    dmemWe_d   = 1'b0;
                    dmemBe_d   = 4'b0000;
                    state_d    = WB;
                end
            end
            WB: begin
                pc_d      = nextPc;
                instret_d = instret_q + CNT_W'(1);
                imemReq_d = 1'b1;
                state_d   = FETCH;
            end
            HALT: ;
            default: state_d = HALT;
        endcase
    end

    // Control FSM state register; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_VECTOR;
            ir_q        <= '0;
            instret_q   <= '0;
            imemReq_q   <= 1'b0;
            dmemReq_q   <= 1'b0;
            dmemWe_q    <= 1'b0;
            dmemBe_q    <= 4'b0000;
            dmemAddr_q  <= '0;
            dmemWdata_q <= '0;
            loadData_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            instret_q   <= instret_d;
            imemReq_q   <= imemReq_d;
            dmemReq_q   <= dmemReq_d;
            dmemWe_q    <= dmemWe_d;
            dmemBe_q    <= dmemBe_d;
            dmemAddr_q  <= dmemAddr_d;
            dmemWdata_q <= dmemWdata_d;
            loadData_q  <= loadData_d;
        end
    end

    // Register file: active-low clear derived from the core reset, single
    // write port used only in WB; rd = x0 is never written.
    assign rfRstN = ~rst;

    always_ff @(posedge clk) begin
        if (!rfRstN) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if ((state_q == WB) && rfWe && (rd != 5'd0)) begin
            rf_q[rd] <= wbData;
        end
    end

    assign imem_req   = imemReq_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmemReq_q;
    assign dmem_we    = dmemWe_q;
    assign dmem_be    = dmemBe_q;
    assign dmem_addr  = dmemAddr_q;
    assign dmem_wdata = dmemWdata_q;
    assign current_pc = pc_q;
    assign instret    = instret_q;
    assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_processor_mc.sv
// tb_processor_mc - directed self-checking bench for processor_mc.
//
// A single initial block runs every scenario. Memory responses are produced
// inside applyStimulus on the falling edge, and DUT outputs are sampled 1ns
// after each rising edge.
module tb_processor_mc;

    localparam logic [31:0] RV      = 32'h0000_0100;
    localparam logic [6:0]  OPC_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_LUI = 7'b0110111;
    localparam logic [6:0]  OPC_LD  = 7'b0000011;
    localparam logic [6:0]  OPC_ST  = 7'b0100011;
    localparam logic [6:0]  OPC_BR  = 7'b1100011;
    localparam logic [6:0]  OPC_JAL = 7'b1101111;
    localparam logic [6:0]  OPC_JR  = 7'b1100111;
    localparam logic [31:0] EBREAK  = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [4:0]  dbg_reg_addr;
    logic [31:0] dbg_reg_val, current_pc, instret;
    logic        halted;

    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    int imemWaitCnt, dmemWaitCnt, storeCount, imemReqSeen, dmemReqSeen;
    int checks, errors;

    processor_mc #(
        .RESET_VECTOR   (RV),
        .CNT_W          (32),
        .HALT_ON_ILLEGAL(1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_be     (dmem_be),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ready  (dmem_ready),
        .dmem_rdata  (dmem_rdata),
        .dbg_reg_addr(dbg_reg_addr),
        .dbg_reg_val (dbg_reg_val),
        .current_pc  (current_pc),
        .instret     (instret),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Hard time limit so a stuck DUT can never hang the run.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int idx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    function automatic logic [31:0] encI(input int imm, input int rs1, input logic [2:0] f3,
                                         input int rd, input logic [6:0] op);
        logic [11:0] i;
        logic [4:0]  s, d;
        i = imm[11:0];
        s = rs1[4:0];
        d = rd[4:0];
        return {i, s, f3, d, op};
    endfunction

    function automatic logic [31:0] encS(input int imm, input int rs2, input int rs1,
                                         input logic [2:0] f3);
        logic [11:0] i;
        logic [4:0]  s1, s2;
        i  = imm[11:0];
        s1 = rs1[4:0];
        s2 = rs2[4:0];
        return {i[11:5], s2, s1, f3, i[4:0], OPC_ST};
    endfunction

    function automatic logic [31:0] encB(input int imm, input int rs2, input int rs1,
                                         input logic [2:0] f3);
        logic [12:0] i;
        logic [4:0]  s1, s2;
        i  = imm[12:0];
        s1 = rs1[4:0];
        s2 = rs2[4:0];
        return {i[12], i[10:5], s2, s1, f3, i[4:1], i[11], OPC_BR};
    endfunction

    function automatic logic [31:0] encJ(input int imm, input int rd);
        logic [20:0] i;
        logic [4:0]  d;
        i = imm[20:0];
        d = rd[4:0];
        return {i[20], i[10:1], i[11], i[19:12], d, OPC_JAL};
    endfunction

    // Advance n clock cycles. On each falling edge the instruction and data
    // memories answer any pending request, honouring the wait counters;
    // stores are merged into the data memory model by byte enable.
    task automatic applyStimulus(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            imem_ready = 1'b0;
            dmem_ready = 1'b0;
            if (imem_req === 1'b1) begin
                imemReqSeen++;
                if (imemWaitCnt > 0) begin
                    imemWaitCnt--;
                end else begin
                    imem_ready = 1'b1;
                    imem_rdata = imem[idx(imem_addr)];
                end
            end
            if (dmem_req === 1'b1) begin
                dmemReqSeen++;
                if (dmemWaitCnt > 0) begin
                    dmemWaitCnt--;
                end else begin
                    dmem_ready = 1'b1;
                    if (dmem_we) begin
                        for (int b = 0; b < 4; b++) begin
                            if (dmem_be[b]) dmem[idx(dmem_addr)][8*b +: 8] = dmem_wdata[8*b +: 8];
                        end
                        storeCount++;
                    end else begin
                        dmem_rdata = dmem[idx(dmem_addr)];
                    end
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkReg(input string tag, input int r, input logic [31:0] exp);
        dbg_reg_addr = r[4:0];
        #1;
        checkOutput(tag, dbg_reg_val, exp);
    endtask

    task automatic clearMem();
        for (int i = 0; i < 256; i++) begin
            imem[i] = EBREAK;
            dmem[i] = '0;
        end
    endtask

    // Two reset cycles; returns right after the last reset edge with rst low.
    task automatic resetCore();
        rst         = 1'b1;
        imemWaitCnt = 0;
        dmemWaitCnt = 0;
        applyStimulus(2);
        rst         = 1'b0;
        imemReqSeen = 0;
        dmemReqSeen = 0;
        storeCount  = 0;
    endtask

    task automatic waitDmemReq(input string tag, input int budget);
        int n;
        n = 0;
        while (dmem_req !== 1'b1 && n < budget) begin
            applyStimulus(1);
            n++;
        end
        checkOutput(tag, dmem_req, 1'b1);
    endtask

    task automatic waitDmemIdle(input string tag, input int budget);
        int n;
        n = 0;
        while (dmem_req !== 1'b0 && n < budget) begin
            applyStimulus(1);
            n++;
        end
        checkOutput(tag, dmem_req, 1'b0);
    endtask

    task automatic waitInstret(input string tag, input logic [31:0] target, input int budget);
        int n;
        n = 0;
        while (instret !== target && n < budget) begin
            applyStimulus(1);
            n++;
        end
        checkOutput(tag, instret, target);
    endtask

    task automatic waitHalt(input string tag, input int budget);
        int n;
        n = 0;
        while (halted !== 1'b1 && n < budget) begin
            applyStimulus(1);
            n++;
        end
        checkOutput(tag, halted, 1'b1);
    endtask

    initial begin
        int bad;
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        imem_ready   = 1'b0;
        imem_rdata   = '0;
        dmem_ready   = 1'b0;
        dmem_rdata   = '0;
        dbg_reg_addr = '0;

        // Reset values and two back-to-back ALU instructions.
        $display("[TB] reset and ALU retire");
        clearMem();
        imem[idx(32'h100)] = encI(5, 0, 3'b000, 1, OPC_IMM);
        imem[idx(32'h104)] = encI(-7, 1, 3'b000, 2, OPC_IMM);
        resetCore();
        checkOutput("rst_imem_req", imem_req, 1'b0);
        checkOutput("rst_dmem_req", dmem_req, 1'b0);
        checkOutput("rst_pc", current_pc, RV);
        checkOutput("rst_instret", instret, 32'd0);
        checkOutput("rst_halted", halted, 1'b0);
        checkReg("rst_x1", 1, 32'd0);
        applyStimulus(1);
        checkOutput("first_req", imem_req, 1'b1);
        checkOutput("first_addr", imem_addr, 32'h100);
        applyStimulus(3);
        checkOutput("alu1_instret", instret, 32'd1);
        checkOutput("alu1_addr", imem_addr, 32'h104);
        checkOutput("alu1_req", imem_req, 1'b1);
        applyStimulus(3);
        checkOutput("alu2_instret", instret, 32'd2);
        checkReg("alu_x1", 1, 32'd5);
        checkReg("alu_x2", 2, 32'hFFFF_FFFE);

        // Byte store lanes then a sign-extended byte load.
        $display("[TB] store lanes and signed load");
        clearMem();
        imem[idx(32'h100)] = encI(32'h200, 0, 3'b000, 1, OPC_IMM);
        imem[idx(32'h104)] = {20'h80818, 5'd2, OPC_LUI};
        imem[idx(32'h108)] = encI(32'h283, 2, 3'b000, 2, OPC_IMM);
        imem[idx(32'h10C)] = encS(1, 2, 1, 3'b000);
        imem[idx(32'h110)] = encI(1, 1, 3'b000, 3, OPC_LD);
        resetCore();
        waitDmemReq("sb_req", 40);
        checkOutput("sb_we", dmem_we, 1'b1);
        checkOutput("sb_be", dmem_be, 4'b0010);
        checkOutput("sb_addr", dmem_addr, 32'h200);
        checkOutput("sb_wdata", dmem_wdata, 32'h8383_8383);
        waitDmemIdle("sb_done", 10);
        waitDmemReq("lb_req", 20);
        checkOutput("lb_we", dmem_we, 1'b0);
        checkOutput("lb_be", dmem_be, 4'b0000);
        checkOutput("lb_addr", dmem_addr, 32'h200);
        waitHalt("lane_halt", 20);
        checkOutput("lane_mem", dmem[idx(32'h200)], 32'h0000_8300);
        checkOutput("lane_stores", storeCount, 32'd1);
        checkOutput("lane_instret", instret, 32'd5);
        checkOutput("lane_pc", current_pc, 32'h114);
        checkReg("lane_x2", 2, 32'h8081_8283);
        checkReg("lane_x3", 3, 32'hFFFF_FF83);

        // Wait states on both memories around a word load.
        $display("[TB] wait states");
        clearMem();
        imem[idx(32'h100)] = encI(32'h200, 0, 3'b000, 1, OPC_IMM);
        imem[idx(32'h104)] = encI(4, 1, 3'b010, 4, OPC_LD);
        dmem[idx(32'h204)] = 32'hDEAD_BEEF;
        resetCore();
        applyStimulus(2);
        imemWaitCnt = 3;
        dmemWaitCnt = 2;
        applyStimulus(2);
        checkOutput("ws_start_pc", current_pc, 32'h104);
        checkOutput("ws_start_instret", instret, 32'd1);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (imem_req !== 1'b1 || imem_addr !== 32'h104) bad++;
            if (k < 3) applyStimulus(1);
        end
        checkOutput("ws_fetch_stable", bad, 32'd0);
        applyStimulus(2);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            if (dmem_req !== 1'b1 || dmem_addr !== 32'h204 || dmem_we !== 1'b0) bad++;
            if (instret !== 32'd1) bad++;
            if (k < 2) applyStimulus(1);
        end
        checkOutput("ws_mem_stable", bad, 32'd0);
        applyStimulus(1);
        checkOutput("ws_pre_retire", instret, 32'd1);
        applyStimulus(1);
        checkOutput("ws_retire", instret, 32'd2);
        checkOutput("ws_pc", current_pc, 32'h108);
        checkReg("ws_x4", 4, 32'hDEAD_BEEF);

        // Taken backward branch, then a jalr to a misaligned target.
        $display("[TB] branch, jalr and x0");
        clearMem();
        imem[idx(32'h100)] = encI(32'h200, 0, 3'b000, 5, OPC_IMM);
        imem[idx(32'h104)] = encJ(28, 0);
        imem[idx(32'h120)] = encB(-8, 0, 0, 3'b000);
        imem[idx(32'h118)] = encI(3, 5, 3'b000, 0, OPC_JR);
        resetCore();
        waitInstret("jal_retire", 32'd2, 30);
        checkOutput("jal_pc", current_pc, 32'h120);
        waitInstret("beq_retire", 32'd3, 30);
        checkOutput("beq_pc", current_pc, 32'h118);
        waitHalt("jalr_halt", 30);
        checkOutput("jalr_pc", current_pc, 32'h118);
        checkOutput("jalr_instret", instret, 32'd3);
        checkReg("jalr_x0", 0, 32'd0);
        checkReg("jalr_x5", 5, 32'h200);

        // ebreak halts in place and stays quiet.
        $display("[TB] ebreak halt");
        clearMem();
        imem[idx(32'h100)] = encJ(32'h40, 0);
        imem[idx(32'h140)] = EBREAK;
        resetCore();
        waitHalt("ebreak_halt", 30);
        checkOutput("ebreak_pc", current_pc, 32'h140);
        checkOutput("ebreak_instret", instret, 32'd1);
        imemReqSeen = 0;
        dmemReqSeen = 0;
        applyStimulus(20);
        checkOutput("ebreak_quiet_i", imemReqSeen, 32'd0);
        checkOutput("ebreak_quiet_d", dmemReqSeen, 32'd0);
        checkOutput("ebreak_stays", halted, 1'b1);

        // Misaligned word load halts without touching data memory.
        $display("[TB] misaligned load halt");
        clearMem();
        imem[idx(32'h100)] = encI(32'h200, 0, 3'b000, 1, OPC_IMM);
        imem[idx(32'h104)] = encI(3, 1, 3'b010, 6, OPC_LD);
        imem[idx(32'h108)] = encI(1, 0, 3'b000, 7, OPC_IMM);
        resetCore();
        waitHalt("mis_halt", 30);
        checkOutput("mis_pc", current_pc, 32'h104);
        checkOutput("mis_instret", instret, 32'd1);
        imemReqSeen = 0;
        applyStimulus(20);
        checkOutput("mis_no_dreq", dmemReqSeen, 32'd0);
        checkOutput("mis_quiet_i", imemReqSeen, 32'd0);
        checkReg("mis_x6", 6, 32'd0);

        // Reset while a store is outstanding abandons it.
        $display("[TB] reset mid-access");
        clearMem();
        imem[idx(32'h100)] = encI(32'h200, 0, 3'b000, 1, OPC_IMM);
        imem[idx(32'h104)] = encI(32'h55, 0, 3'b000, 2, OPC_IMM);
        imem[idx(32'h108)] = encS(0, 2, 1, 3'b010);
        resetCore();
        dmemWaitCnt = 1000;
        waitDmemReq("sw_req", 40);
        checkOutput("sw_we", dmem_we, 1'b1);
        checkOutput("sw_be", dmem_be, 4'b1111);
        checkOutput("sw_wdata", dmem_wdata, 32'h55);
        checkOutput("sw_instret", instret, 32'd2);
        rst = 1'b1;
        applyStimulus(1);
        checkOutput("abort_dreq", dmem_req, 1'b0);
        checkOutput("abort_ireq", imem_req, 1'b0);
        checkOutput("abort_pc", current_pc, RV);
        checkOutput("abort_instret", instret, 32'd0);
        checkOutput("abort_stores", storeCount, 32'd0);
        checkReg("abort_x1", 1, 32'd0);
        rst = 1'b0;
        dmemWaitCnt = 0;
        waitInstret("rerun_retire", 32'd3, 40);
        checkOutput("rerun_stores", storeCount, 32'd1);
        checkOutput("rerun_mem", dmem[idx(32'h200)], 32'h55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/processor_mc.md
# processor_mc

Multi-cycle RV32I core: the parametrised successor to the single-cycle `processor`. It reuses the `alu`, `br_alu`, `decode` and `reg_file` blocks. Instruction and data memories sit behind separate req/ready handshakes, so wait-stated memories are supported. It adds sized loads/stores with byte enables, a retired-instruction counter, and a halt state for `ebreak`, illegal and misaligned instructions. It replaces `processor` as the top-level core in the design.

## Interface
- `RESET_VECTOR`, 32'h0000_0000, PC value loaded on reset.
- `CNT_W`, 32, width of the `instret` counter (1..64).
- `HALT_ON_ILLEGAL`, 1: 1 = halt on undecodable opcode; 0 = treat it as a NOP.
- `clk` in 1: single clock, all state on the rising edge.
- `rst` in 1: synchronous, active-high reset. Drive the embedded `reg_file` reset from `~rst`.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out 32: fetch address, always equals `current_pc`.
- `imem_ready` in 1: fetch completes in the cycle where it is high together with `imem_req`.
- `imem_rdata` in 32: instruction word, valid when `imem_ready` is high.
- `dmem_req` out 1: data request.
- `dmem_we` out 1: 1 = store, 0 = load.
- `dmem_be` out 4: byte enables for stores; 4'b0000 on loads.
- `dmem_addr` out 32: word-aligned address, `{ea[31:2],2'b00}`.
- `dmem_wdata` out 32: store data, lane-replicated.
- `dmem_ready` in 1: data transfer completes when it is high together with `dmem_req`.
- `dmem_rdata` in 32: load word, valid when `dmem_ready` is high.
- `dbg_reg_addr` in 5: debug register-file read address (combinational read).
- `dbg_reg_val` out 32: value of that register; reads 0 for x0.
- `current_pc` out 32: architectural PC of the instruction in flight.
- `instret` out CNT_W: count of retired instructions.
- `halted` out 1: high while in HALT.

## Operation
- FSM states: FETCH, EXEC, MEM, WB, HALT.
- **FETCH**
  - Hold `imem_req`=1 and `imem_addr`=pc until `imem_ready`.
  - On ready, latch `imem_rdata` into the IR and go to EXEC.
- **EXEC** (always one cycle)
  - Decode the IR, read rs1/rs2, compute the ALU result, branch outcome and next_pc.
  - The next_pc mux is the same as in the single-cycle core: pc+4, pc+imm, (rs1+imm)&~1, or branch-conditional.
  - Loads/stores go to MEM. `ebreak` goes to HALT. Everything else goes to WB.
- **MEM**
  - Effective address ea = rs1+imm.
  - Hold `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be` and `dmem_wdata` stable until `dmem_ready`.
  - On ready, latch load data and go to WB.
- **Store byte enables and data**
  - sb: `be`=4'b0001<<ea[1:0], `wdata`={4{rs2[7:0]}}.
  - sh: `be`=ea[1]?4'b1100:4'b0011, `wdata`={2{rs2[15:0]}}.
  - sw: `be`=4'b1111, `wdata`=rs2.
- **Loads**: select the byte/halfword lane by ea[1:0]. lb/lh sign-extend; lbu/lhu zero-extend.
- **WB**
  - Write rd if `rf_we`; writes to x0 are discarded.
  - pc <= next_pc; `instret` <= `instret`+1 (wraps modulo 2^CNT_W); go to FETCH.
- **Fault conditions → HALT from EXEC, with no register write, no memory request, no `instret` increment**
  - Misaligned halfword (ea[0]=1) or word (ea[1:0]≠0) access.
  - Taken jump/branch target with target[1:0]≠0.
  - Illegal opcode when `HALT_ON_ILLEGAL`=1.
- **HALT**
  - Absorbing state: `halted`=1, no requests.
  - pc stays at the faulting or `ebreak` instruction. `ebreak` does not retire.
  - Only `rst` exits HALT.

## Timing
- **Reset values** (registered the edge after `rst` is sampled high):
  - state=FETCH, pc=`RESET_VECTOR`, `instret`=0, `halted`=0.
  - `imem_req`=0, `dmem_req`=0, `dmem_we`=0, `dmem_be`=0, IR=0.
  - Register file cleared.
  - `imem_req` rises on the first cycle after `rst` deasserts.
- **Zero-wait latency**
  - ALU/branch/jump instructions: 3 cycles (FETCH, EXEC, WB).
  - Loads/stores: 4 cycles.
  - Each wait cycle on ready adds 1 cycle.
- **Request rules**
  - All request outputs are registered.
  - A request is never withdrawn before ready.
  - Ready while req=0 is ignored.
- **Reset mid-transaction**: an outstanding request is abandoned. req is low on the edge after `rst`, and no register or `instret` update occurs.
- **Visibility of updates**
  - `instret` and `current_pc` both update on the WB edge.
  - `dbg_reg_val` reflects a WB write from the following cycle.

## Test plan
- **Reset and ALU retire**: reset with `RESET_VECTOR`=32'h100, zero-wait memories running `addi x1,x0,5; addi x2,x1,-7` → `imem_addr` 0x100 then 0x104; x2 reads 32'hFFFF_FFFE; `instret`=2 after 6 cycles.
- **Store lanes and signed load**: x1=0x200, x2=0x8081_8283; `sb x2,1(x1)` → `be`=4'b0010, `addr`=0x200, `wdata`=32'h8383_8383. Then `lb x3,1(x1)` with memory returning 32'h0000_8300 → x3=32'hFFFF_FF83.
- **Wait states**: hold `imem_ready` low 3 cycles and `dmem_ready` low 2 cycles on `lw` → req and addr stay stable throughout; the instruction completes in 9 cycles; `instret` increments exactly once.
- **Branch, jalr and x0**:
  - `beq` taken with imm=-8 at pc 0x120 → next fetch at 0x118.
  - `jalr x0,3(x5)` with x5=0x200 → fetch at 0x202 → HALT (misaligned target); x0 stays 0.
- **Halt conditions**: `ebreak` at 0x140 → `halted`=1, `current_pc`=0x140, `instret` unchanged, no further requests for 20 cycles. Same check for `lw` with ea=0x203.
- **Reset mid-access**: assert `rst` while `dmem_req`=1 on `sw` → `dmem_req`=0 the next cycle; no store is completed; pc returns to `RESET_VECTOR`; `instret`=0.
